// File: rtl/store_queue_fwd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : store_queue_fwd                                            |
// | Description : Program-ordered store queue with commit, multi-outstanding |
// |               dcache drain, per-byte load forwarding and fence status.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module store_queue_fwd #(
  parameter int DEPTH        = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int MAX_OUTST    = 2
) (
  input  logic                              i_clk,
  input  logic                              i_resetn,
  input  logic                              i_flush,
  input  logic                              i_enq_valid,
  output logic                              o_enq_ready,
  input  logic [31:0]                       i_enq_addr,
  input  logic [3:0]                        i_enq_wstrb,
  input  logic [2:0]                        i_enq_size,
  input  logic [31:0]                       i_enq_data,
  input  logic                              i_enq_uncached,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0] i_commit_cnt,
  input  logic [31:0]                       i_ld_addr,
  input  logic [3:0]                        i_ld_wstrb,
  input  logic                              i_ld_uncached,
  output logic                              o_ld_fwd_hit,
  output logic [31:0]                       o_ld_fwd_data,
  output logic [3:0]                        o_ld_fwd_mask,
  output logic                              o_ld_conflict,
  output logic                              o_dc_req,
  input  logic                              i_dc_addr_ok,
  input  logic                              i_dc_data_ok,
  output logic [31:0]                       o_dc_addr,
  output logic [3:0]                        o_dc_wstrb,
  output logic [2:0]                        o_dc_size,
  output logic [31:0]                       o_dc_wdata,
  output logic                              o_dc_uncached,
  input  logic                              i_fence_req,
  output logic                              o_fence_done,
  output logic [$clog2(DEPTH):0]            o_sq_count
);

  localparam int c_IW = $clog2(DEPTH);
  localparam int c_PW = c_IW + 1;
  localparam int c_OW = $clog2(MAX_OUTST + 1);
  localparam logic [c_PW-1:0] c_FULL = c_PW'(DEPTH);
  localparam logic [c_OW-1:0] c_MAX  = c_OW'(MAX_OUTST);

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [c_PW-1:0] r_head, r_issue, r_commit, r_tail;
  logic [31:0]     r_addr  [DEPTH];
  logic [3:0]      r_wstrb [DEPTH];
  logic [2:0]      r_size  [DEPTH];
  logic [31:0]     r_data  [DEPTH];
  logic            r_unc   [DEPTH];

  logic            r_dc_req;
  logic [31:0]     r_dc_addr, r_dc_wdata;
  logic [3:0]      r_dc_wstrb;
  logic [2:0]      r_dc_size;
  logic            r_dc_unc;
  logic [c_OW-1:0] r_outst;
  logic            r_unc_pend;   // an uncached store is in flight; block younger ones

  logic [c_PW-1:0] w_count, w_commit_nx;
  logic [c_IW-1:0] w_iss_idx;
  logic            w_enq, w_acc, w_issue;
  logic [31:0]     w_fwd_data;
  logic [3:0]      w_fwd_mask;
  logic            w_word_hit, w_unc_hit;
  logic            w_unused_ok;

  assign w_count     = r_tail - r_head;
  assign w_commit_nx = r_commit + c_PW'(i_commit_cnt);
  assign w_enq       = i_enq_valid && o_enq_ready && !i_flush;
  assign w_acc       = r_dc_req && i_dc_addr_ok;
  assign w_iss_idx   = r_issue[c_IW-1:0];
  // Uncached stores need an idle bus; anything behind one waits for its data_ok.
  assign w_issue     = (r_issue != r_commit) && (r_outst < c_MAX) &&
                       (!r_dc_req || i_dc_addr_ok) && !r_unc_pend &&
                       (!r_unc[w_iss_idx] || (r_outst == '0 && !r_dc_req));

  assign o_enq_ready   = (w_count != c_FULL);
  assign o_sq_count    = w_count;
  assign o_fence_done  = (r_head == r_commit) && !r_dc_req && (r_outst == '0);
  assign o_dc_req      = r_dc_req;
  assign o_dc_addr     = r_dc_addr;
  assign o_dc_wstrb    = r_dc_wstrb;
  assign o_dc_size     = r_dc_size;
  assign o_dc_wdata    = r_dc_wdata;
  assign o_dc_uncached = r_dc_unc;
  assign w_unused_ok   = &{1'b0, i_fence_req, i_ld_addr[1:0]};

  // Queue pointers: enqueue, commit, flush truncation, issue and free.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_head   <= '0;
      r_issue  <= '0;
      r_commit <= '0;
      r_tail   <= '0;
    end else begin
      r_commit <= w_commit_nx;
      if (i_flush)      r_tail  <= w_commit_nx;
      else if (w_enq)   r_tail  <= r_tail + c_PW'(1);
      if (w_issue)      r_issue <= r_issue + c_PW'(1);
      if (i_dc_data_ok) r_head  <= r_head + c_PW'(1);
    end
  end

  // Request valid, in-flight count and uncached ordering flag.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_dc_req   <= 1'b0;
      r_outst    <= '0;
      r_unc_pend <= 1'b0;
    end else begin
      if (w_issue)    r_dc_req <= 1'b1;
      else if (w_acc) r_dc_req <= 1'b0;
      if (w_acc && !i_dc_data_ok)      r_outst <= r_outst + c_OW'(1);
      else if (!w_acc && i_dc_data_ok) r_outst <= r_outst - c_OW'(1);
      if (w_issue && r_unc[w_iss_idx]) r_unc_pend <= 1'b1;
      else if (i_dc_data_ok)           r_unc_pend <= 1'b0;
    end
  end

  // Entry payload storage; validity is implied by the [head,tail) range.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_addr [r_tail[c_IW-1:0]] <= i_enq_addr;
      r_wstrb[r_tail[c_IW-1:0]] <= i_enq_wstrb;
      r_size [r_tail[c_IW-1:0]] <= i_enq_size;
      r_data [r_tail[c_IW-1:0]] <= i_enq_data;
      r_unc  [r_tail[c_IW-1:0]] <= i_enq_uncached;
    end
  end

  // Request payload loads on issue and holds until the next issue.
  always_ff @(posedge i_clk) begin
    if (w_issue) begin
      r_dc_addr  <= r_addr [w_iss_idx];
      r_dc_wstrb <= r_wstrb[w_iss_idx];
      r_dc_size  <= r_size [w_iss_idx];
      r_dc_wdata <= r_data [w_iss_idx];
      r_dc_unc   <= r_unc  [w_iss_idx];
    end
  end

  // Walk oldest to youngest so later matches overwrite earlier ones per lane.
  always_comb begin : p_fwd
    logic [c_PW-1:0] w_ptr;
    w_ptr      = '0;
    w_fwd_data = '0;
    w_fwd_mask = '0;
    w_word_hit = 1'b0;
    w_unc_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ptr = r_head + c_PW'(i);
      if ((c_PW'(i) < w_count) && (r_addr[w_ptr[c_IW-1:0]][31:2] == i_ld_addr[31:2])) begin
        w_word_hit = 1'b1;
        if (r_unc[w_ptr[c_IW-1:0]]) w_unc_hit = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (r_wstrb[w_ptr[c_IW-1:0]][b]) begin
            w_fwd_mask[b]       = 1'b1;
            w_fwd_data[8*b +: 8] = r_data[w_ptr[c_IW-1:0]][8*b +: 8];
          end
        end
      end
    end
    if (w_enq && (i_enq_addr[31:2] == i_ld_addr[31:2])) begin
      w_word_hit = 1'b1;
      if (i_enq_uncached) w_unc_hit = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (i_enq_wstrb[b]) begin
          w_fwd_mask[b]       = 1'b1;
          w_fwd_data[8*b +: 8] = i_enq_data[8*b +: 8];
        end
      end
    end
  end

  // Uncached involvement suppresses forwarding and forces the load to wait.
  always_comb begin
    o_ld_fwd_hit  = 1'b0;
    o_ld_fwd_data = '0;
    o_ld_fwd_mask = '0;
    o_ld_conflict = 1'b0;
    if (w_unc_hit || (i_ld_uncached && w_word_hit)) begin
      o_ld_conflict = 1'b1;
    end else begin
      o_ld_fwd_mask = w_fwd_mask;
      o_ld_fwd_data = w_fwd_data;
      o_ld_fwd_hit  = (i_ld_wstrb != 4'b0) && ((w_fwd_mask & i_ld_wstrb) == i_ld_wstrb);
      o_ld_conflict = w_word_hit &&
                      !((i_ld_wstrb != 4'b0) && ((w_fwd_mask & i_ld_wstrb) == i_ld_wstrb));
    end
  end

  a_commit_range: assert property (@(posedge i_clk) disable iff (!i_resetn)
    c_PW'(i_commit_cnt) <= (r_tail - r_commit));
  a_data_ok_outst: assert property (@(posedge i_clk) disable iff (!i_resetn)
    i_dc_data_ok |-> (r_outst != '0));

endmodule
`default_nettype wire

// File: tb/tb_store_queue_fwd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_store_queue_fwd                                         |
// | Description : Scenario bench for store_queue_fwd with a dcache model and |
// |               an ordered scoreboard of expected dcache requests.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_store_queue_fwd;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [31:0] data;
    logic        unc;
  } st_t;

  logic        clk = 1'b0;
  logic        i_resetn, i_flush, i_enq_valid, i_enq_uncached, i_ld_uncached;
  logic        i_dc_addr_ok, i_dc_data_ok, i_fence_req;
  logic [31:0] i_enq_addr, i_enq_data, i_ld_addr;
  logic [3:0]  i_enq_wstrb, i_ld_wstrb;
  logic [2:0]  i_enq_size;
  logic [1:0]  i_commit_cnt;
  logic        o_enq_ready, o_ld_fwd_hit, o_ld_conflict, o_dc_req, o_dc_uncached, o_fence_done;
  logic [31:0] o_ld_fwd_data, o_dc_addr, o_dc_wdata;
  logic [3:0]  o_ld_fwd_mask, o_dc_wstrb;
  logic [2:0]  o_dc_size;
  logic [4:0]  o_sq_count;

  st_t m_pend[$];   // enqueued, not yet committed
  st_t sb_q[$];     // committed, expected on the dcache port in order
  int  total = 0, bad = 0;
  int  m_inflight = 0, n_acc = 0;
  bit  m_unc_pend = 0;
  bit  dc_accept = 0, dc_auto = 0;

  always #5 clk = ~clk;

  store_queue_fwd #(.DEPTH(16), .COMMIT_WIDTH(2), .MAX_OUTST(2)) dut (
    .i_clk(clk), .i_resetn(i_resetn), .i_flush(i_flush),
    .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
    .i_enq_addr(i_enq_addr), .i_enq_wstrb(i_enq_wstrb), .i_enq_size(i_enq_size),
    .i_enq_data(i_enq_data), .i_enq_uncached(i_enq_uncached),
    .i_commit_cnt(i_commit_cnt),
    .i_ld_addr(i_ld_addr), .i_ld_wstrb(i_ld_wstrb), .i_ld_uncached(i_ld_uncached),
    .o_ld_fwd_hit(o_ld_fwd_hit), .o_ld_fwd_data(o_ld_fwd_data),
    .o_ld_fwd_mask(o_ld_fwd_mask), .o_ld_conflict(o_ld_conflict),
    .o_dc_req(o_dc_req), .i_dc_addr_ok(i_dc_addr_ok), .i_dc_data_ok(i_dc_data_ok),
    .o_dc_addr(o_dc_addr), .o_dc_wstrb(o_dc_wstrb), .o_dc_size(o_dc_size),
    .o_dc_wdata(o_dc_wdata), .o_dc_uncached(o_dc_uncached),
    .i_fence_req(i_fence_req), .o_fence_done(o_fence_done), .o_sq_count(o_sq_count)
  );

  // Two-slot dcache model plus scoreboard pop on every accepted request.
  initial begin : dcache_model
    bit  acc, dok;
    st_t exp_s, got_s;
    i_dc_addr_ok = 1'b0;
    i_dc_data_ok = 1'b0;
    forever begin
      @(negedge clk);
      acc = o_dc_req && i_dc_addr_ok;
      dok = i_dc_data_ok;
      if (acc) begin
        n_acc++;
        total++;
        got_s = {o_dc_addr, o_dc_wstrb, o_dc_size, o_dc_wdata, o_dc_uncached};
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL dc_unexpected got=%h exp=none", got_s);
        end else begin
          exp_s = sb_q.pop_front();
          if (got_s !== exp_s) begin
            bad++;
            $display("FAIL dc_payload got=%h exp=%h", got_s, exp_s);
          end
        end
      end
      @(posedge clk);
      #1;
      if (!i_resetn) begin
        m_inflight = 0;
        m_unc_pend = 0;
      end else begin
        m_inflight = m_inflight + (acc ? 1 : 0) - (dok ? 1 : 0);
        if (dok) m_unc_pend = 0;
        if (acc && o_dc_uncached === 1'b1) m_unc_pend = 1;
      end
      i_dc_addr_ok = dc_accept && (m_inflight < 2);
      i_dc_data_ok = dc_auto && (m_inflight > 0) && i_resetn;
    end
  end

  function automatic st_t mk(input logic [31:0] a, input logic [3:0] w,
                             input logic [31:0] d, input logic u);
    st_t s;
    s.addr = a; s.wstrb = w; s.size = 3'd2; s.data = d; s.unc = u;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input st_t s);
    i_enq_valid = 1'b1;
    i_enq_addr = s.addr; i_enq_wstrb = s.wstrb; i_enq_size = s.size;
    i_enq_data = s.data; i_enq_uncached = s.unc;
    m_pend.push_back(s);
    tick();
    i_enq_valid = 1'b0;
  endtask

  task automatic commit_n(input int n);
    i_commit_cnt = n[1:0];
    repeat (n) sb_q.push_back(m_pend.pop_front());
    tick();
    i_commit_cnt = '0;
  endtask

  task automatic flush_n(input int n, input bit with_enq);
    i_commit_cnt = n[1:0];
    i_flush = 1'b1;
    repeat (n) sb_q.push_back(m_pend.pop_front());
    m_pend.delete();
    if (with_enq) begin
      i_enq_valid = 1'b1; i_enq_addr = 32'h3F0; i_enq_wstrb = 4'hF;
      i_enq_data = 32'hDEAD_BEEF; i_enq_uncached = 1'b0;
    end
    tick();
    i_flush = 1'b0; i_enq_valid = 1'b0; i_commit_cnt = '0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_fence_done && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    i_resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_resetn = 1'b1;
    tick();
    @(negedge clk);
    total++; if (o_enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%b exp=1", o_enq_ready); end
    total++; if (o_fence_done !== 1'b1) begin bad++; $display("FAIL reset_fence_done got=%b exp=1", o_fence_done); end
    total++; if (o_sq_count !== 5'd0) begin bad++; $display("FAIL reset_sq_count got=%0d exp=0", o_sq_count); end
    total++; if (o_dc_req !== 1'b0) begin bad++; $display("FAIL reset_dc_req got=%b exp=0", o_dc_req); end
    total++;
    if ({o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask, o_ld_fwd_data} !== 38'd0) begin
      bad++; $display("FAIL reset_ld_outputs got=%b/%b/%h/%h exp=0", o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask, o_ld_fwd_data);
    end
    tick();
  endtask

  task automatic test_fill();
    bit ok;
    int n0;
    dc_accept = 1; dc_auto = 0; n0 = n_acc;
    for (int i = 0; i < 16; i++) enq(mk(32'h1000 + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i), 1'b0));
    @(negedge clk);
    total++; if (o_enq_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", o_enq_ready); end
    total++; if (o_sq_count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", o_sq_count); end
    tick();
    commit_n(2);
    repeat (6) tick();
    @(negedge clk);
    total++; if (o_enq_ready !== 1'b0) begin bad++; $display("FAIL fill_committed_ready got=%b exp=0", o_enq_ready); end
    total++; if (n_acc - n0 != 2) begin bad++; $display("FAIL fill_accepted got=%0d exp=2", n_acc - n0); end
    tick();
    dc_auto = 1;
    repeat (10) tick();
    @(negedge clk);
    total++; if (o_sq_count !== 5'd14) begin bad++; $display("FAIL fill_freed_count got=%0d exp=14", o_sq_count); end
    total++; if (o_enq_ready !== 1'b1) begin bad++; $display("FAIL fill_freed_ready got=%b exp=1", o_enq_ready); end
    tick();
    for (int i = 0; i < 7; i++) begin
      commit_n(2);
      drain(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL fill_drain_%0d got=timeout exp=drained", i); end
    end
  endtask

  task automatic test_merge_fwd();
    enq(mk(32'h100, 4'b0011, 32'h0000_BBAA, 1'b0));
    enq(mk(32'h102, 4'b1100, 32'hDDCC_0000, 1'b0));
    i_ld_addr = 32'h100; i_ld_wstrb = 4'hF; i_ld_uncached = 1'b0;
    @(negedge clk);
    total++;
    if ({o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask, o_ld_fwd_data} !== {1'b1, 1'b0, 4'hF, 32'hDDCC_BBAA}) begin
      bad++; $display("FAIL merge_two got=%b/%b/%h/%h exp=1/0/f/ddccbbaa", o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask, o_ld_fwd_data);
    end
    tick();
    i_enq_valid = 1'b1; i_enq_addr = 32'h100; i_enq_wstrb = 4'b0001;
    i_enq_data = 32'h0000_00EE; i_enq_uncached = 1'b0; i_enq_size = 3'd2;
    m_pend.push_back(mk(32'h100, 4'b0001, 32'h0000_00EE, 1'b0));
    @(negedge clk);
    total++; if (o_ld_fwd_data !== 32'hDDCC_BBEE) begin bad++; $display("FAIL merge_enq_cycle got=%h exp=ddccbbee", o_ld_fwd_data); end
    tick();
    i_enq_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({o_ld_fwd_hit, o_ld_fwd_data} !== {1'b1, 32'hDDCC_BBEE}) begin
      bad++; $display("FAIL merge_three got=%b/%h exp=1/ddccbbee", o_ld_fwd_hit, o_ld_fwd_data);
    end
    tick();
    i_ld_uncached = 1'b1;
    @(negedge clk);
    total++;
    if ({o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask} !== {1'b0, 1'b1, 4'h0}) begin
      bad++; $display("FAIL merge_uncached_load got=%b/%b/%h exp=0/1/0", o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask);
    end
    tick();
    i_ld_uncached = 1'b0;
    flush_n(0, 1'b0);
    @(negedge clk);
    total++; if (o_sq_count !== 5'd0) begin bad++; $display("FAIL merge_flush_count got=%0d exp=0", o_sq_count); end
    tick();
  endtask

  task automatic test_partial();
    enq(mk(32'h200, 4'b0001, 32'h0000_0011, 1'b0));
    i_ld_addr = 32'h200; i_ld_wstrb = 4'b0011;
    @(negedge clk);
    total++;
    if ({o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask, o_ld_fwd_data} !== {1'b0, 1'b1, 4'b0001, 32'h11}) begin
      bad++; $display("FAIL partial_hit got=%b/%b/%h/%h exp=0/1/1/00000011", o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask, o_ld_fwd_data);
    end
    tick();
    i_ld_addr = 32'h204;
    @(negedge clk);
    total++;
    if ({o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask} !== 6'd0) begin
      bad++; $display("FAIL partial_miss got=%b/%b/%h exp=0/0/0", o_ld_fwd_hit, o_ld_conflict, o_ld_fwd_mask);
    end
    tick();
    i_ld_wstrb = 4'h0;
    flush_n(0, 1'b0);
  endtask

  task automatic test_flush();
    bit ok;
    int n0;
    dc_accept = 0; dc_auto = 1;
    tick();
    n0 = n_acc;
    for (int i = 0; i < 5; i++) enq(mk(32'h300 + 32'(4*i), 4'hF, 32'hB000_0000 + 32'(i), 1'b0));
    commit_n(2);
    flush_n(1, 1'b1);
    @(negedge clk);
    total++; if (o_sq_count !== 5'd3) begin bad++; $display("FAIL flush_count got=%0d exp=3", o_sq_count); end
    tick();
    dc_accept = 1;
    drain(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL flush_drain got=timeout exp=drained"); end
    total++; if (n_acc - n0 != 3) begin bad++; $display("FAIL flush_req_count got=%0d exp=3", n_acc - n0); end
    @(negedge clk);
    total++; if (o_sq_count !== 5'd0) begin bad++; $display("FAIL flush_final_count got=%0d exp=0", o_sq_count); end
    tick();
  endtask

  task automatic test_outstanding();
    bit seen_unc, seen_next, done;
    int n0;
    dc_accept = 1; dc_auto = 0; n0 = n_acc;
    for (int i = 0; i < 5; i++) enq(mk(32'h400 + 32'(4*i), 4'hF, 32'hC000_0000 + 32'(i), (i == 3)));
    commit_n(2); commit_n(2); commit_n(1);
    repeat (6) tick();
    @(negedge clk);
    total++; if (n_acc - n0 != 2) begin bad++; $display("FAIL outst_accepted got=%0d exp=2", n_acc - n0); end
    total++;
    if ({o_dc_req, o_dc_addr} !== {1'b1, 32'h408}) begin
      bad++; $display("FAIL outst_third_req got=%b/%h exp=1/00000408", o_dc_req, o_dc_addr);
    end
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({o_dc_req, o_dc_addr, o_dc_wdata} !== {1'b1, 32'h408, 32'hC000_0002}) begin
      bad++; $display("FAIL outst_held got=%b/%h/%h exp=1/00000408/c0000002", o_dc_req, o_dc_addr, o_dc_wdata);
    end
    tick();
    dc_auto = 1;
    seen_unc = 0; seen_next = 0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (o_dc_req && o_dc_uncached && !seen_unc) begin
        seen_unc = 1;
        total++; if (m_inflight != 0) begin bad++; $display("FAIL outst_unc_wait got=%0d exp=0", m_inflight); end
      end
      if (o_dc_req && !o_dc_uncached && o_dc_addr == 32'h410 && !seen_next) begin
        seen_next = 1;
        total++; if (m_unc_pend || !seen_unc) begin bad++; $display("FAIL outst_after_unc got=%b exp=0", m_unc_pend); end
      end
      done = o_fence_done && (sb_q.size() == 0);
    end
    total++;
    if ({seen_unc, seen_next, done} !== 3'b111) begin
      bad++; $display("FAIL outst_complete got=%b exp=111", {seen_unc, seen_next, done});
    end
    tick();
  endtask

  task automatic test_fence();
    bit ok;
    i_fence_req = 1'b1;
    dc_accept = 1; dc_auto = 0;
    for (int i = 0; i < 3; i++) enq(mk(32'h500 + 32'(4*i), 4'b0101, 32'hE000_0000 + 32'(i), 1'b0));
    @(negedge clk);
    total++; if (o_fence_done !== 1'b1) begin bad++; $display("FAIL fence_uncommitted got=%b exp=1", o_fence_done); end
    tick();
    commit_n(2);
    @(negedge clk);
    total++; if (o_fence_done !== 1'b0) begin bad++; $display("FAIL fence_after_commit got=%b exp=0", o_fence_done); end
    tick();
    commit_n(1);
    repeat (5) tick();
    @(negedge clk);
    total++; if (o_fence_done !== 1'b0) begin bad++; $display("FAIL fence_draining got=%b exp=0", o_fence_done); end
    tick();
    dc_auto = 1;
    drain(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL fence_done_timeout got=timeout exp=done"); end
    @(negedge clk);
    total++; if (o_sq_count !== 5'd0) begin bad++; $display("FAIL fence_count got=%0d exp=0", o_sq_count); end
    tick();
    i_fence_req = 1'b0;
  endtask

  task automatic test_reset_midburst();
    dc_accept = 1; dc_auto = 0;
    for (int i = 0; i < 6; i++) enq(mk(32'h600 + 32'(4*i), 4'hF, 32'hF000_0000 + 32'(i), 1'b0));
    commit_n(2); commit_n(2);
    tick();
    @(negedge clk);
    #2;
    i_resetn = 1'b0;
    #1;
    total++; if (o_dc_req !== 1'b0) begin bad++; $display("FAIL rst_mid_dc_req got=%b exp=0", o_dc_req); end
    total++; if (o_sq_count !== 5'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", o_sq_count); end
    total++;
    if ({o_enq_ready, o_fence_done} !== 2'b11) begin
      bad++; $display("FAIL rst_mid_status got=%b exp=11", {o_enq_ready, o_fence_done});
    end
    sb_q.delete();
    m_pend.delete();
    tick();
    i_resetn = 1'b1;
    dc_auto = 1;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({o_dc_req, o_sq_count} !== 6'd0) begin
      bad++; $display("FAIL rst_mid_after got=%b/%0d exp=0/0", o_dc_req, o_sq_count);
    end
  endtask

  initial begin
    i_resetn = 1'b0; i_flush = 1'b0; i_enq_valid = 1'b0; i_enq_uncached = 1'b0;
    i_enq_addr = '0; i_enq_data = '0; i_enq_wstrb = '0; i_enq_size = 3'd2;
    i_commit_cnt = '0; i_ld_addr = '0; i_ld_wstrb = '0; i_ld_uncached = 1'b0;
    i_fence_req = 1'b0;
    test_reset();
    test_fill();
    test_merge_fwd();
    test_partial();
    test_flush();
    test_outstanding();
    test_fence();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
